// File: rtl/stream_demux_pkg.sv
// Shared types and helpers for the stream_demux block.
//   state_e       : holding-register state (ST_EMPTY / ST_FULL)
//   CNT_W         : width of each per-channel delivered-beat counter
//   DROP_CNT_W    : width of the saturating dropped-beat counter
//   sel_in_range  : true when a binary select addresses an existing channel
package stream_demux_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  localparam int CNT_W      = 16;
  localparam int DROP_CNT_W = 8;

  // Select values >= n only occur when n is not a power of two.
  function automatic logic sel_in_range(input logic [31:0] sel, input int unsigned n);
    return (sel < n);
  endfunction

endpackage

// File: rtl/sel_decoder.sv
// Combinational binary-to-one-hot decoder.
// Ports:
//   sel_i    : binary channel index
//   en_i     : decode enable; all outputs zero when low
//   onehot_o : one-hot channel vector; all zero when disabled or sel_i >= N_OUT
module sel_decoder #(
  parameter int N_OUT = 4,
  parameter int SEL_W = $clog2(N_OUT)
) (
  input  logic [SEL_W-1:0] sel_i,
  input  logic             en_i,
  output logic [N_OUT-1:0] onehot_o
);

  // An out-of-range select matches no bit, so it decodes to zero for free.
  for (genvar k = 0; k < N_OUT; k++) begin : g_bit
    assign onehot_o[k] = en_i && (sel_i == SEL_W'(k));
  end

endmodule

// File: rtl/stream_demux.sv
// Registered 1-to-N stream demultiplexer.
// A single holding register carries one beat to the channel named by its
// select tag; the slot is refilled in the same cycle it drains, so a ready
// destination sees one beat per clock.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : input handshake
//   in_data, in_sel     : input payload and destination channel index
//   out_valid[N_OUT]    : per-channel valid, one-hot or zero
//   out_ready[N_OUT]    : per-channel ready from consumers
//   out_data            : shared payload bus
//   drop                : one-cycle pulse after an out-of-range beat is discarded
// Optional build macro STREAM_DEMUX_STATS_EN adds:
//   drop_cnt            : saturating count of dropped beats
//   beat_cnt            : per-channel delivered-beat counters, channel 0 in LSBs
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int N_OUT = 4,
  parameter int W     = 8,
  localparam int SEL_W = $clog2(N_OUT)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [W-1:0]            in_data,
  input  logic [SEL_W-1:0]        in_sel,
  output logic [N_OUT-1:0]        out_valid,
  input  logic [N_OUT-1:0]        out_ready,
  output logic [W-1:0]            out_data,
`ifdef STREAM_DEMUX_STATS_EN
  output logic [DROP_CNT_W-1:0]   drop_cnt,
  output logic [N_OUT*CNT_W-1:0]  beat_cnt,
`endif
  output logic                    drop
);

  state_e           state_q, state_d;
  logic [W-1:0]     data_q, data_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             drop_q, drop_d;

  logic             in_fire, out_fire, in_ok;
  logic [N_OUT-1:0] fire_vec;

  sel_decoder #(.N_OUT(N_OUT), .SEL_W(SEL_W)) u_dec (
    .sel_i    (sel_q),
    .en_i     (state_q == ST_FULL),
    .onehot_o (out_valid)
  );

  // out_valid is one-hot on sel_q, so masking with out_ready picks exactly
  // the destination's ready and ignores every other lane.
  assign fire_vec = out_valid & out_ready;
  assign out_fire = |fire_vec;
  assign in_ready = (state_q == ST_EMPTY) || out_fire;
  assign in_fire  = in_valid && in_ready;
  assign in_ok    = sel_in_range(32'(in_sel), N_OUT);

  assign out_data = data_q;
  assign drop     = drop_q;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    drop_d  = 1'b0;
    if (out_fire) state_d = ST_EMPTY;
    if (in_fire) begin
      if (in_ok) begin
        // Load wins over drain: drain + load in one cycle stays FULL.
        state_d = ST_FULL;
        data_d  = in_data;
        sel_d   = in_sel;
      end else begin
        drop_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      sel_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      drop_q  <= drop_d;
    end
  end

`ifdef STREAM_DEMUX_STATS_EN
  logic [DROP_CNT_W-1:0] drop_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      drop_cnt_q <= '0;
    else if (drop_d && (drop_cnt_q != {DROP_CNT_W{1'b1}}))
      drop_cnt_q <= drop_cnt_q + 1'b1;
  end

  assign drop_cnt = drop_cnt_q;

  for (genvar k = 0; k < N_OUT; k++) begin : g_cnt
    logic [CNT_W-1:0] cnt_q;
    // Free-running wrap at 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        cnt_q <= '0;
      else if (fire_vec[k])
        cnt_q <= cnt_q + 1'b1;
    end
    assign beat_cnt[k*CNT_W +: CNT_W] = cnt_q;
  end
`endif

endmodule

// File: tb/tb_stream_demux.sv
// Bench for stream_demux: a one-slot behavioural model checked every cycle
// on the 4-channel instance, plus directed literal checks on it and on a
// 3-channel instance that exercises out-of-range selects.
module tb_stream_demux;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 4-channel instance
  logic       in_valid, in_ready, drop;
  logic [7:0] in_data, out_data;
  logic [1:0] in_sel;
  logic [3:0] out_valid, out_ready;
`ifdef STREAM_DEMUX_STATS_EN
  logic [7:0]  drop_cnt;
  logic [63:0] beat_cnt;
`endif

  // 3-channel instance
  logic       in_valid3, in_ready3, drop3;
  logic [7:0] in_data3, out_data3;
  logic [1:0] in_sel3;
  logic [2:0] out_valid3, out_ready3;
`ifdef STREAM_DEMUX_STATS_EN
  logic [7:0]  drop_cnt3;
  logic [47:0] beat_cnt3;
`endif

  stream_demux #(.N_OUT(4), .W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
`ifdef STREAM_DEMUX_STATS_EN
    .drop_cnt(drop_cnt), .beat_cnt(beat_cnt),
`endif
    .drop(drop)
  );

  stream_demux #(.N_OUT(3), .W(8)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data3), .in_sel(in_sel3),
    .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3),
`ifdef STREAM_DEMUX_STATS_EN
    .drop_cnt(drop_cnt3), .beat_cnt(beat_cnt3),
`endif
    .drop(drop3)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model of the 4-channel instance: a single slot that holds at most one beat.
  bit       m_full = 0;
  bit [7:0] m_data = 0;
  int       m_sel  = 0;
  bit       m_drop = 0;
  int       m_beat [4] = '{0, 0, 0, 0};
  int       m_dropc = 0;
  int       fires  [4] = '{0, 0, 0, 0};

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_out_valid", out_valid, 4'b0000);
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_drop", drop, 1'b0);
      chk("rst_out_data", out_data, 8'h00);
      m_full = 0; m_drop = 0; m_dropc = 0;
      for (int k = 0; k < 4; k++) m_beat[k] = 0;
    end else begin
      logic [3:0] exp_v;
      bit dst_rdy, acc;
      exp_v = m_full ? 4'(1 << m_sel) : 4'b0000;
      dst_rdy = m_full && out_ready[m_sel];
      chk("out_valid", out_valid, exp_v);
      if (m_full) chk("out_data", out_data, m_data);
      chk("in_ready", in_ready, !m_full || dst_rdy);
      chk("drop", drop, m_drop);
`ifdef STREAM_DEMUX_STATS_EN
      chk("drop_cnt", drop_cnt, m_dropc);
      for (int k = 0; k < 4; k++) chk("beat_cnt", beat_cnt[k*16 +: 16], m_beat[k]);
`endif
      for (int k = 0; k < 4; k++) if (out_valid[k] && out_ready[k]) fires[k]++;
      // advance to the state after the coming rising edge
      acc = in_valid && (!m_full || dst_rdy);
      if (dst_rdy) begin
        m_beat[m_sel] = (m_beat[m_sel] + 1) % 65536;
        m_full = 0;
      end
      m_drop = 0;
      if (acc) begin
        if (in_sel < 4) begin
          m_full = 1; m_data = in_data; m_sel = in_sel;
        end else begin
          m_drop = 1;
          if (m_dropc < 255) m_dropc++;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic [1:0] s);
    in_valid = 1'b1; in_data = d; in_sel = s;
  endtask

  initial begin
    int f2;
    in_valid = 0; in_data = 0; in_sel = 0; out_ready = 0;
    in_valid3 = 0; in_data3 = 0; in_sel3 = 0; out_ready3 = 0;
    rst_n = 0;
    cyc(); cyc();
    rst_n = 1;
    cyc();

    // Streaming to three different channels back to back
    out_ready = 4'hF;
    send(8'h11, 2'd0); #1 chk("st_in_ready0", in_ready, 1'b1);
    cyc(); chk("st_v0", out_valid, 4'b0001); chk("st_d0", out_data, 8'h11);
    send(8'h22, 2'd3); #1 chk("st_in_ready1", in_ready, 1'b1);
    cyc(); chk("st_v1", out_valid, 4'b1000); chk("st_d1", out_data, 8'h22);
    send(8'h33, 2'd1); #1 chk("st_in_ready2", in_ready, 1'b1);
    cyc(); chk("st_v2", out_valid, 4'b0010); chk("st_d2", out_data, 8'h33);
    in_valid = 0;
    cyc(); chk("st_drained", out_valid, 4'b0000);

    // Backpressure on ch2 for three cycles
    f2 = fires[2];
    out_ready = 4'b1011;
    send(8'hA5, 2'd2);
    cyc(); in_valid = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_v", out_valid, 4'b0100); chk("bp_d", out_data, 8'hA5);
      chk("bp_in_ready", in_ready, 1'b0);
      cyc();
    end
    out_ready = 4'hF; #1
    chk("bp_v_last", out_valid, 4'b0100); chk("bp_in_ready_go", in_ready, 1'b1);
    cyc(); chk("bp_drained", out_valid, 4'b0000);
    cyc(); chk("bp_one_xfer", fires[2] - f2, 1);

    // Non-selected ready lanes are ignored; then drain and reload in one cycle
    out_ready = 4'b1101;
    send(8'h5C, 2'd1);
    cyc(); send(8'h66, 2'd0);
    #1 chk("ns_in_ready", in_ready, 1'b0);
    cyc(); chk("ns_v", out_valid, 4'b0010); chk("ns_d", out_data, 8'h5C);
    out_ready = 4'hF;
    cyc(); chk("ns_reload_v", out_valid, 4'b0001); chk("ns_reload_d", out_data, 8'h66);
    in_valid = 0;
    cyc(); chk("ns_drained", out_valid, 4'b0000);

    // Asynchronous reset while holding a stalled beat for ch2
    out_ready = 4'b1011;
    send(8'h99, 2'd2);
    cyc(); in_valid = 0;
    chk("rs_held", out_valid, 4'b0100);
    #2 rst_n = 0;
    #1 chk("rs_async_v", out_valid, 4'b0000); chk("rs_async_rdy", in_ready, 1'b1);
    chk("rs_async_drop", drop, 1'b0);
    cyc(); cyc();
    rst_n = 1; out_ready = 4'hF;
    cyc(); chk("rs_after_v", out_valid, 4'b0000);

    // Delivery counts: 5 beats to ch0, 2 to ch3
    for (int i = 0; i < 5; i++) begin send(8'(i), 2'd0); cyc(); end
    for (int i = 0; i < 2; i++) begin send(8'(8'h40 + i), 2'd3); cyc(); end
    in_valid = 0;
    cyc(); cyc();
`ifdef STREAM_DEMUX_STATS_EN
    chk("cnt_ch0", beat_cnt[15:0], 16'd5);
    chk("cnt_ch1", beat_cnt[31:16], 16'd0);
    chk("cnt_ch2", beat_cnt[47:32], 16'd0);
    chk("cnt_ch3", beat_cnt[63:48], 16'd2);
`endif

    // Out-of-range select on the 3-channel instance, concurrent with a drain
    out_ready3 = 3'b111;
    in_valid3 = 1; in_data3 = 8'h42; in_sel3 = 2'd1;
    cyc(); chk("n3_v", out_valid3, 3'b010); chk("n3_d", out_data3, 8'h42);
    in_data3 = 8'h7E; in_sel3 = 2'd3;
    #1 chk("n3_oor_rdy", in_ready3, 1'b1);
    cyc(); in_valid3 = 0;
    chk("n3_drop", drop3, 1'b1); chk("n3_oor_v", out_valid3, 3'b000);
`ifdef STREAM_DEMUX_STATS_EN
    chk("n3_drop_cnt1", drop_cnt3, 8'd1);
    chk("n3_cnt_ch1", beat_cnt3[31:16], 16'd1);
`endif
    cyc(); chk("n3_drop_pulse", drop3, 1'b0); chk("n3_idle_v", out_valid3, 3'b000);

    // Saturation of the drop counter
    in_valid3 = 1; in_sel3 = 2'd3;
    for (int i = 0; i < 300; i++) begin in_data3 = 8'(i); cyc(); end
    in_valid3 = 0;
    cyc();
    chk("n3_drop_end", drop3, 1'b0);
`ifdef STREAM_DEMUX_STATS_EN
    chk("n3_drop_sat", drop_cnt3, 8'd255);
`endif
    chk("n3_final_v", out_valid3, 3'b000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
